// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM driving ALU code, datapath selects and enables from op/funct3/funct7b5/Zero; define BRANCH_NE_EN to add bne
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControls,
  output logic [3:0] state_dbg
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10
  } state_t;
  state_t state, next;
  logic pc_update, branch, take, mem_write, ir_write, reg_write;
  logic [1:0] alu_op;
  logic [2:0] funct_ctl;
  always_ff @(posedge clk) state <= reset ? FETCH : next;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = DECODE;
      DECODE:   next = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
                       op == 7'b0110011 ? EXECUTER :
                       op == 7'b0010011 ? EXECUTEI :
                       op == 7'b1100011 ? BEQ :
                       op == 7'b1101111 ? JAL : FETCH;
      MEMADR:   next = op == 7'b0000011 ? MEMREAD : MEMWRITE;
      MEMREAD:  next = MEMWB;
      EXECUTER, EXECUTEI, JAL: next = ALUWB;
      default:  next = FETCH;
    endcase
  end
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    case (state)
      FETCH:    begin ir_write = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_update = 1'b1; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; reg_write = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; mem_write = 1'b1; end
      EXECUTER: begin ALUSrcA = 2'b10; alu_op = 2'b10; end
      EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = 2'b10; end
      ALUWB:    reg_write = 1'b1;
      BEQ:      begin ALUSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1; end
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      default:  ;
    endcase
  end
  assign funct_ctl = funct3 == 3'b000 ? {2'b00, op[5] & funct7b5} :
                     funct3 == 3'b010 ? 3'b101 :
                     funct3 == 3'b110 ? 3'b011 :
                     funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign ALUControls = alu_op == 2'b01 ? 3'b001 : alu_op == 2'b10 ? funct_ctl : 3'b000;
`ifdef BRANCH_NE_EN
  assign take = funct3 == 3'b001 ? ~Zero : Zero;
`else
  assign take = Zero;
`endif
  assign PCWrite   = ~reset & (pc_update | (branch & take));
  assign MemWrite  = ~reset & mem_write;
  assign IRWrite   = ~reset & ir_write;
  assign RegWrite  = ~reset & reg_write;
  assign ImmSrc    = op == 7'b0100011 ? 2'b01 : op == 7'b1100011 ? 2'b10 : op == 7'b1101111 ? 2'b11 : 2'b00;
  assign state_dbg = state;
endmodule
